// File: rtl/rm_task_dispatcher_if.sv
// rm_task_dispatcher_if: dispatch offer and completion handshake between dispatcher and worker
interface rm_task_dispatcher_if #(
    parameter int ID_W = 32
);
    logic            dispatch_valid;
    logic [ID_W-1:0] dispatch_id;
    logic            dispatch_ready;
    logic            done_valid;
    logic [ID_W-1:0] done_id;
    modport master (
        output dispatch_valid, dispatch_id,
        input  dispatch_ready, done_valid, done_id
    );
    modport slave (
        input  dispatch_valid, dispatch_id,
        output dispatch_ready, done_valid, done_id
    );
endinterface

// File: rtl/rm_task_dispatcher.sv
// rm_task_dispatcher: queues rate-monotonic releases and hands them lowest-id-first to one non-preemptive worker
module rm_task_dispatcher #(
    parameter int NUM_TASKS = 3,
    parameter int ID_W      = 32,
    parameter int TIMEOUT   = 64,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ID_W-1:0]      rel_id,
    rm_task_dispatcher_if.master disp,
    output logic [ID_W-1:0]      running_id,
    output logic [NUM_TASKS-1:0] queued_mask,
    output logic                 overrun_pulse,
    output logic [ID_W-1:0]      overrun_id,
    output logic [CNT_W-1:0]     overrun_count,
    output logic                 timeout_pulse,
    output logic                 bad_id_pulse
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    typedef enum logic [1:0] {IDLE, OFFER, RUN} state_t;
    state_t                state, state_n;
    logic                  offer_valid, offer_valid_n;
    logic [ID_W-1:0]       offer_id, offer_id_n, running_n, low_id;
    logic [TW-1:0]         timer, timer_n;
    logic [NUM_TASKS-1:0]  rel_hit, offer_hit, run_hit, pend, accept, queued_n;
    logic                  done_ok, handshake, tmo, overrun, bad;
    assign disp.dispatch_valid = offer_valid;
    assign disp.dispatch_id    = offer_id;
    // decode ids to slot bits, pick the highest-priority queued slot, and resolve same-cycle events
    always_comb begin
        rel_hit   = '0;
        offer_hit = '0;
        run_hit   = '0;
        low_id    = '0;
        for (int i = NUM_TASKS - 1; i >= 0; i--) begin
            rel_hit[i]   = rel_id == ID_W'(i + 1);
            offer_hit[i] = offer_id == ID_W'(i + 1);
            run_hit[i]   = running_id == ID_W'(i + 1);
            if (queued_mask[i]) low_id = ID_W'(i + 1);
        end
        done_ok   = state == RUN && disp.done_valid && disp.done_id == running_id;
        handshake = state == OFFER && disp.dispatch_ready;
        tmo       = state == RUN && !done_ok && timer == TW'(TIMEOUT - 1);
        pend      = queued_mask | ((state == RUN && !done_ok) ? run_hit : '0);
        overrun   = |(rel_hit & pend);
        accept    = rel_hit & ~pend;
        bad       = rel_id > ID_W'(NUM_TASKS) || (disp.done_valid && !done_ok);
        queued_n  = (queued_mask & ~(handshake ? offer_hit : '0)) | accept;
    end
    // next-state and registered-output logic for the IDLE/OFFER/RUN controller
    always_comb begin
        state_n       = state;
        offer_valid_n = offer_valid;
        offer_id_n    = offer_id;
        running_n     = running_id;
        timer_n       = timer;
        unique case (state)
            IDLE: if (|queued_mask) begin
                state_n       = OFFER;
                offer_valid_n = 1'b1;
                offer_id_n    = low_id;
            end
            OFFER: if (disp.dispatch_ready) begin
                state_n       = RUN;
                offer_valid_n = 1'b0;
                offer_id_n    = '0;
                running_n     = offer_id;
                timer_n       = '0;
            end
            RUN: begin
                timer_n = timer + TW'(1);
                if (done_ok || tmo) begin
                    state_n   = IDLE;
                    running_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    // state register, pending bitmap and event flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            offer_valid   <= 1'b0;
            offer_id      <= '0;
            running_id    <= '0;
            timer         <= '0;
            queued_mask   <= '0;
            overrun_pulse <= 1'b0;
            overrun_id    <= '0;
            overrun_count <= '0;
            timeout_pulse <= 1'b0;
            bad_id_pulse  <= 1'b0;
        end else begin
            state         <= state_n;
            offer_valid   <= offer_valid_n;
            offer_id      <= offer_id_n;
            running_id    <= running_n;
            timer         <= timer_n;
            queued_mask   <= queued_n;
            overrun_pulse <= overrun;
            overrun_id    <= overrun ? rel_id : overrun_id;
            overrun_count <= (overrun && !(&overrun_count)) ? overrun_count + CNT_W'(1) : overrun_count;
            timeout_pulse <= tmo;
            bad_id_pulse  <= bad;
        end
    end
endmodule

// File: tb/tb_rm_task_dispatcher.sv
// tb_rm_task_dispatcher: directed and random stimulus checked against a behavioural dispatcher model
module tb_rm_task_dispatcher;
    localparam int N  = 3;
    localparam int IW = 32;
    localparam int TO = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [IW-1:0] rel_id = '0;
    logic [IW-1:0] running_id, overrun_id;
    logic [N-1:0]  queued_mask;
    logic          overrun_pulse, timeout_pulse, bad_id_pulse;
    logic [CW-1:0] overrun_count;
    rm_task_dispatcher_if #(.ID_W(IW)) bus ();
    rm_task_dispatcher #(.NUM_TASKS(N), .ID_W(IW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .rel_id(rel_id), .disp(bus),
        .running_id(running_id), .queued_mask(queued_mask),
        .overrun_pulse(overrun_pulse), .overrun_id(overrun_id), .overrun_count(overrun_count),
        .timeout_pulse(timeout_pulse), .bad_id_pulse(bad_id_pulse)
    );
    always #5 clk = ~clk;
    int  total = 0;
    int  bad = 0;
    bit  mq [1:N];
    int  m_off, m_run, m_t, m_ovid, m_cnt;
    bit  m_ovp, m_tmo, m_bad;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        bit done_ok, tmo, ov, acc, rv;
        int r;
        logic [N-1:0] em;
        if (reset) begin
            foreach (mq[i]) mq[i] = 1'b0;
            m_off = 0; m_run = 0; m_t = 0; m_ovid = 0; m_cnt = 0;
            m_ovp = 0; m_tmo = 0; m_bad = 0;
        end else begin
            rv = rel_id >= 1 && rel_id <= N;
            r = rv ? int'(rel_id) : 0;
            done_ok = m_run != 0 && bus.done_valid && longint'(bus.done_id) == longint'(m_run);
            m_bad = rel_id > N || (bus.done_valid && !done_ok);
            tmo = m_run != 0 && !done_ok && m_t == TO - 1;
            ov = rv && (mq[r] || (m_run == r && !done_ok));
            acc = rv && !ov;
            m_ovp = ov;
            m_tmo = tmo;
            if (ov) begin
                m_ovid = r;
                m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
            end
            if (m_off != 0) begin
                if (bus.dispatch_ready) begin
                    mq[m_off] = 1'b0;
                    m_run = m_off;
                    m_t = 0;
                    m_off = 0;
                end
            end else if (m_run != 0) begin
                if (done_ok || tmo) m_run = 0;
                else m_t++;
            end else begin
                for (int i = N; i >= 1; i--) if (mq[i]) m_off = i;
            end
            if (acc) mq[r] = 1'b1;
        end
        @(posedge clk);
        #1;
        for (int i = 1; i <= N; i++) em[i-1] = mq[i];
        check("dispatch_valid", 64'(bus.dispatch_valid), 64'(m_off != 0));
        check("dispatch_id", 64'(bus.dispatch_id), 64'(m_off));
        check("running_id", 64'(running_id), 64'(m_run));
        check("queued_mask", 64'(queued_mask), 64'(em));
        check("overrun_pulse", 64'(overrun_pulse), 64'(m_ovp));
        check("overrun_id", 64'(overrun_id), 64'(m_ovid));
        check("overrun_count", 64'(overrun_count), 64'(m_cnt));
        check("timeout_pulse", 64'(timeout_pulse), 64'(m_tmo));
        check("bad_id_pulse", 64'(bad_id_pulse), 64'(m_bad));
    endtask
    initial begin
        bus.dispatch_ready = 1'b0;
        bus.done_valid = 1'b0;
        bus.done_id = '0;
        tick();
        tick();
        check("rst_running", 64'(running_id), 64'd0);
        check("rst_valid", 64'(bus.dispatch_valid), 64'd0);
        reset = 1'b0;
        bus.dispatch_ready = 1'b1;
        rel_id = 2;
        tick();
        check("single_queued", 64'(queued_mask), 64'b010);
        rel_id = 0;
        tick();
        check("single_offer_valid", 64'(bus.dispatch_valid), 64'd1);
        check("single_offer_id", 64'(bus.dispatch_id), 64'd2);
        tick();
        check("single_running", 64'(running_id), 64'd2);
        tick();
        tick();
        bus.done_valid = 1'b1;
        bus.done_id = 2;
        tick();
        check("single_done", 64'(running_id), 64'd0);
        bus.done_valid = 1'b0;
        bus.dispatch_ready = 1'b0;
        rel_id = 2;
        tick();
        tick();
        check("ovr_pulse", 64'(overrun_pulse), 64'd1);
        check("ovr_id", 64'(overrun_id), 64'd2);
        check("ovr_count", 64'(overrun_count), 64'd1);
        rel_id = 3;
        tick();
        check("ovr_one_cycle", 64'(overrun_pulse), 64'd0);
        rel_id = 1;
        tick();
        check("offer_stable_id", 64'(bus.dispatch_id), 64'd2);
        check("offer_queued", 64'(queued_mask), 64'b111);
        rel_id = 0;
        bus.dispatch_ready = 1'b1;
        tick();
        check("prio_run2", 64'(running_id), 64'd2);
        bus.done_valid = 1'b1;
        bus.done_id = 2;
        tick();
        bus.done_valid = 1'b0;
        tick();
        check("prio_first", 64'(bus.dispatch_id), 64'd1);
        tick();
        check("prio_run1", 64'(running_id), 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("tmo_early", 64'(timeout_pulse), 64'd0);
        end
        tick();
        check("tmo_pulse", 64'(timeout_pulse), 64'd1);
        check("tmo_running", 64'(running_id), 64'd0);
        tick();
        check("prio_second", 64'(bus.dispatch_id), 64'd3);
        tick();
        tick();
        tick();
        tick();
        bus.done_valid = 1'b1;
        bus.done_id = 3;
        tick();
        check("done_beats_tmo", 64'(timeout_pulse), 64'd0);
        check("done_beats_tmo_run", 64'(running_id), 64'd0);
        bus.done_valid = 1'b0;
        rel_id = 7;
        tick();
        check("bad_rel", 64'(bad_id_pulse), 64'd1);
        check("bad_rel_mask", 64'(queued_mask), 64'd0);
        rel_id = 0;
        bus.done_valid = 1'b1;
        bus.done_id = 1;
        tick();
        check("bad_done_idle", 64'(bad_id_pulse), 64'd1);
        bus.done_valid = 1'b0;
        rel_id = 1;
        tick();
        rel_id = 0;
        tick();
        tick();
        bus.done_valid = 1'b1;
        bus.done_id = 3;
        tick();
        check("bad_done_run", 64'(bad_id_pulse), 64'd1);
        check("bad_done_stays", 64'(running_id), 64'd1);
        bus.done_valid = 1'b0;
        reset = 1'b1;
        tick();
        check("mid_run_reset", 64'(running_id), 64'd0);
        check("mid_run_reset_cnt", 64'(overrun_count), 64'd0);
        reset = 1'b0;
        bus.dispatch_ready = 1'b0;
        rel_id = 1;
        for (int k = 0; k < 20; k++) tick();
        check("sat_count", 64'(overrun_count), 64'(CMAX));
        rel_id = 0;
        for (int k = 0; k < 600; k++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            rel_id = sel < 5 ? '0 : sel == 8 ? IW'($urandom_range(4, 40)) : IW'($urandom_range(1, N));
            bus.dispatch_ready = 1'($urandom_range(0, 1));
            bus.done_valid = $urandom_range(0, 3) == 0;
            bus.done_id = $urandom_range(0, 4) != 0 ? IW'(m_run) : IW'($urandom_range(0, 4));
            reset = $urandom_range(0, 199) == 0;
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
